// File: rtl/lf_mode_sequencer.sv
// ============================================================================
// lf_mode_sequencer
// Glitch-free major-mode sequencing and mode configuration state for the LF top.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lf_mode_sequencer #(
  parameter int GUARD_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int RESET_DIVISOR = 95
) (
  input  logic        pck0,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd,
  input  logic [11:0] cmd_data,
  input  logic        ssp_frame_in,
  output logic [2:0]  major_mode,
  output logic        lf_field,
  output logic        lf_ed_toggle_mode,
  output logic [7:0]  divisor,
  output logic [7:0]  lf_ed_threshold,
  output logic        mute,
  output logic        busy,
  output logic        cmd_overflow
);

  localparam logic [2:0] MODE_OFF     = 3'd7;
  localparam logic [2:0] MODE_LF_ED   = 3'd1;
  localparam logic [7:0] THR_DEFAULT  = 8'd127;
  localparam logic [7:0] DRAIN_LAST   = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0] GUARD_LAST   = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] DIV_DEFAULT  = 8'(RESET_DIVISOR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    QUIET = 2'd2,
    APPLY = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  // Conf words are kept packed as {major[2:0], toggle, field}.
  logic [4:0] target;
  logic [4:0] pend;
  logic       pend_valid;

  logic       conf_wr;
  logic       div_wr;
  logic       thr_wr;
  logic [4:0] cmd_conf;
  logic       unused_cmd_bits;

  assign conf_wr         = cmd_valid && (cmd == 4'd1);
  assign div_wr          = cmd_valid && (cmd == 4'd2);
  assign thr_wr          = cmd_valid && (cmd == 4'd3);
  assign cmd_conf        = {cmd_data[8:6], cmd_data[1:0]};
  assign unused_cmd_bits = ^cmd_data[11:9];

  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= 8'd0;
      target            <= 5'd0;
      pend              <= 5'd0;
      pend_valid        <= 1'b0;
      major_mode        <= MODE_OFF;
      lf_field          <= 1'b0;
      lf_ed_toggle_mode <= 1'b0;
      divisor           <= DIV_DEFAULT;
      lf_ed_threshold   <= THR_DEFAULT;
      mute              <= 1'b0;
      busy              <= 1'b0;
      cmd_overflow      <= 1'b0;
    end else begin
      cmd_overflow <= 1'b0;

      // Conf writes while busy land in the one-deep slot; APPLY consumes them directly.
      if (conf_wr && (state != IDLE)) begin
        cmd_overflow <= pend_valid;
        if (state != APPLY) begin
          pend       <= cmd_conf;
          pend_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (conf_wr) begin
            if (cmd_data[8:6] == major_mode) begin
              lf_field          <= cmd_data[0];
              lf_ed_toggle_mode <= cmd_data[1];
            end else begin
              target <= cmd_conf;
              cnt    <= 8'd0;
              busy   <= 1'b1;
              state  <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (!ssp_frame_in || (cnt == DRAIN_LAST)) begin
            cnt        <= 8'd0;
            mute       <= 1'b1;
            major_mode <= MODE_OFF;
            lf_field   <= 1'b0;
            state      <= QUIET;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        QUIET: begin
          if (cnt == GUARD_LAST) begin
            state <= APPLY;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        APPLY: begin
          major_mode        <= target[4:2];
          lf_ed_toggle_mode <= target[1];
          lf_field          <= target[0];
          mute              <= 1'b0;
          if (target[4:2] == MODE_LF_ED) begin
            lf_ed_threshold <= THR_DEFAULT;
          end
          if (conf_wr || pend_valid) begin
            target     <= conf_wr ? cmd_conf : pend;
            pend_valid <= 1'b0;
            cnt        <= 8'd0;
            state      <= DRAIN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Explicit writes come last so they override the APPLY threshold default.
      if (div_wr) begin
        divisor <= cmd_data[7:0];
      end
      if (thr_wr) begin
        lf_ed_threshold <= cmd_data[7:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lf_mode_sequencer.sv
// ============================================================================
// tb_lf_mode_sequencer
// Directed stimulus against a phase/countdown model of the mode sequencer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lf_mode_sequencer;

  localparam int GUARD = 16;
  localparam int DTO   = 64;
  localparam int RDIV  = 95;

  localparam int PH_IDLE  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_QUIET = 2;
  localparam int PH_APPLY = 3;

  logic        pck0 = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [3:0]  cmd;
  logic [11:0] cmd_data;
  logic        ssp_frame_in;
  logic [2:0]  major_mode;
  logic        lf_field;
  logic        lf_ed_toggle_mode;
  logic [7:0]  divisor;
  logic [7:0]  lf_ed_threshold;
  logic        mute;
  logic        busy;
  logic        cmd_overflow;

  lf_mode_sequencer #(
    .GUARD_CYCLES (GUARD),
    .DRAIN_TIMEOUT(DTO),
    .RESET_DIVISOR(RDIV)
  ) dut (
    .pck0             (pck0),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd              (cmd),
    .cmd_data         (cmd_data),
    .ssp_frame_in     (ssp_frame_in),
    .major_mode       (major_mode),
    .lf_field         (lf_field),
    .lf_ed_toggle_mode(lf_ed_toggle_mode),
    .divisor          (divisor),
    .lf_ed_threshold  (lf_ed_threshold),
    .mute             (mute),
    .busy             (busy),
    .cmd_overflow     (cmd_overflow)
  );

  always #5 pck0 = ~pck0;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: spec-level phases with down-counting remaining-cycle budgets.
  int          phase;
  int          left;
  logic [11:0] tgt;
  logic [11:0] pend[$];
  logic [2:0]  m_major;
  logic        m_field, m_tog, m_mute, m_busy, m_ovf;
  logic [7:0]  m_div, m_thr;

  always @(posedge pck0 or posedge reset) begin
    if (reset) begin
      phase = PH_IDLE; left = 0; tgt = '0; pend.delete();
      m_major = 3'd7; m_field = 1'b0; m_tog = 1'b0; m_mute = 1'b0;
      m_busy = 1'b0; m_ovf = 1'b0; m_div = 8'(RDIV); m_thr = 8'd127;
    end else begin
      bit conf;
      int cur;
      conf  = cmd_valid && (cmd == 4'd1);
      cur   = phase;
      m_ovf = 1'b0;
      if (conf && cur != PH_IDLE) begin
        if (pend.size() > 0) m_ovf = 1'b1;
        pend.delete();
        pend.push_back(cmd_data);
      end
      case (cur)
        PH_IDLE: if (conf) begin
          if (cmd_data[8:6] == m_major) begin
            m_field = cmd_data[0];
            m_tog   = cmd_data[1];
          end else begin
            tgt = cmd_data; phase = PH_DRAIN; left = DTO; m_busy = 1'b1;
          end
        end
        PH_DRAIN: begin
          left--;
          if (!ssp_frame_in || left == 0) begin
            phase = PH_QUIET; left = GUARD;
            m_mute = 1'b1; m_major = 3'd7; m_field = 1'b0;
          end
        end
        PH_QUIET: begin
          left--;
          if (left == 0) phase = PH_APPLY;
        end
        default: begin
          m_major = tgt[8:6]; m_field = tgt[0]; m_tog = tgt[1]; m_mute = 1'b0;
          if (tgt[8:6] == 3'd1) m_thr = 8'd127;
          if (pend.size() > 0) begin
            tgt = pend.pop_front(); phase = PH_DRAIN; left = DTO;
          end else begin
            phase = PH_IDLE; m_busy = 1'b0;
          end
        end
      endcase
      if (cmd_valid && cmd == 4'd2) m_div = cmd_data[7:0];
      if (cmd_valid && cmd == 4'd3) m_thr = cmd_data[7:0];
    end
  end

  always @(negedge pck0) begin
    if (run_cmp) begin
      check("major_mode", 16'(major_mode), 16'(m_major));
      check("lf_field", 16'(lf_field), 16'(m_field));
      check("lf_ed_toggle_mode", 16'(lf_ed_toggle_mode), 16'(m_tog));
      check("divisor", 16'(divisor), 16'(m_div));
      check("lf_ed_threshold", 16'(lf_ed_threshold), 16'(m_thr));
      check("mute", 16'(mute), 16'(m_mute));
      check("busy", 16'(busy), 16'(m_busy));
      check("cmd_overflow", 16'(cmd_overflow), 16'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge pck0);
    #2;
  endtask

  task automatic send(input logic [3:0] c, input logic [11:0] d);
    cmd_valid = 1'b1; cmd = c; cmd_data = d;
    tick();
    cmd_valid = 1'b0; cmd = 4'd0; cmd_data = 12'd0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin n++; tick(); end
    check({name, "_idle_timeout"}, 16'(busy), 16'd0);
  endtask

  task automatic wait_mute(input string name);
    int n;
    n = 0;
    while (!mute && n < 200) begin n++; tick(); end
    check({name, "_mute_timeout"}, 16'(mute), 16'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd = 4'd0; cmd_data = 12'd0; ssp_frame_in = 1'b0;
    tick(); tick();
    check("rst_major", 16'(major_mode), 16'd7);
    check("rst_divisor", 16'(divisor), 16'd95);
    check("rst_threshold", 16'(lf_ed_threshold), 16'd127);
    check("rst_mute_busy", 16'({mute, busy, cmd_overflow}), 16'd0);
    reset = 1'b0;
    run_cmp = 1'b1;
    tick();

    // Major 1 with frame low: one drain cycle, 16 quiet + 1 apply muted.
    send(4'd1, 12'h040);
    check("t1_busy_rise", 16'(busy), 16'd1);
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (mute) n++;
      tick();
    end
    check("t1_mute_cycles", 16'(n), 16'd17);
    check("t1_final_major", 16'(major_mode), 16'd1);
    check("t1_final_thr", 16'(lf_ed_threshold), 16'd127);
    check("t1_final_mute_busy", 16'({mute, busy}), 16'd0);

    // Same-major conf update in IDLE takes effect without a sequence.
    send(4'd1, 12'h000);
    wait_idle("t2a");
    send(4'd1, 12'h001);
    check("t2_field", 16'(lf_field), 16'd1);
    check("t2_major", 16'(major_mode), 16'd0);
    check("t2_busy_mute", 16'({busy, mute}), 16'd0);

    // Frame held high: drain exits by timeout.
    ssp_frame_in = 1'b1;
    send(4'd1, 12'h080);
    n = 0;
    while (busy && !mute && n < 200) begin n++; tick(); end
    check("t3_drain_cycles", 16'(n), 16'd64);
    wait_idle("t3");
    ssp_frame_in = 1'b0;
    check("t3_major", 16'(major_mode), 16'd2);

    // Two conf writes while busy: one overflow, then a second sequence.
    send(4'd1, 12'h040);
    wait_mute("t4");
    send(4'd1, 12'h0C0);
    send(4'd1, 12'h080);
    n = 0;
    for (int i = 0; i < 400 && busy; i++) begin
      if (cmd_overflow) n++;
      tick();
    end
    check("t4_overflow_pulses", 16'(n), 16'd1);
    check("t4_major", 16'(major_mode), 16'd2);

    // Divisor/threshold writes during QUIET; APPLY default wins later.
    send(4'd1, 12'h040);
    wait_mute("t5");
    send(4'd2, 12'h058);
    check("t5_divisor", 16'(divisor), 16'd88);
    send(4'd3, 12'h020);
    check("t5_thr_early", 16'(lf_ed_threshold), 16'd32);
    wait_idle("t5");
    check("t5_thr_final", 16'(lf_ed_threshold), 16'd127);

    // Threshold write in the APPLY cycle itself wins over the default.
    send(4'd1, 12'h080);
    wait_idle("t5b");
    send(4'd1, 12'h040);
    wait_mute("t5c");
    repeat (GUARD) tick();
    send(4'd3, 12'h020);
    wait_idle("t5c");
    check("t5_thr_apply_write", 16'(lf_ed_threshold), 16'd32);
    check("t5_major", 16'(major_mode), 16'd1);

    // Reset mid-QUIET drops everything, including the pending write.
    send(4'd1, 12'h080);
    wait_mute("t6");
    send(4'd1, 12'h0C0);
    reset = 1'b1;
    #1;
    check("t6_mute", 16'(mute), 16'd0);
    check("t6_major", 16'(major_mode), 16'd7);
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_divisor", 16'(divisor), 16'd95);
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) n++;
      tick();
    end
    check("t6_no_sequence", 16'(n), 16'd0);
    check("t6_major_after", 16'(major_mode), 16'd7);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lf_mode_sequencer.md
Name: lf_mode_sequencer

Overview:
- Sequences glitch-free major-mode changes for the LF FPGA top.
- Takes decoded SPI command writes, already synchronised into the pck0 domain, and owns the configuration state that drives the mode muxes: conf word fields, divisor and edge-detect threshold.
- On a major-mode change it drains the active SSP frame, then holds all outputs muted in OFF mode for a guard period, then applies the new mode.
- Sits between the SPI command decoder and the mode modules / output muxes.

Parameters:
- GUARD_CYCLES, 16, number of pck0 cycles mute is held high with major_mode forced to OFF (legal range 1..255).
- DRAIN_TIMEOUT, 64, maximum pck0 cycles spent waiting for ssp_frame_in low (legal range 1..255).
- RESET_DIVISOR, 95, divisor value after reset.

Ports:
- pck0  input  1  block clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  one-cycle strobe: cmd/cmd_data valid.
- cmd  input  4  command code: 1 = SET_CONFREG, 2 = SET_DIVISOR, 3 = SET_EDGE_DETECT_THRESHOLD; other codes are ignored.
- cmd_data  input  12  command payload.
- ssp_frame_in  input  1  SSP frame of the currently selected mode (post-mux).
- major_mode  output  3  selected major mode; 7 = OFF, 1 = LF edge detect.
- lf_field  output  1  conf bit 0.
- lf_ed_toggle_mode  output  1  conf bit 1.
- divisor  output  8  clock divider value.
- lf_ed_threshold  output  8  edge-detect threshold.
- mute  output  1  forces coil drivers and SSP outputs inactive.
- busy  output  1  mode-change sequence in progress.
- cmd_overflow  output  1  one-cycle pulse: pending conf write overwritten.

Behaviour:
- All outputs are registered.
- Reset values: major_mode = 7, lf_field = 0, lf_ed_toggle_mode = 0, divisor = RESET_DIVISOR, lf_ed_threshold = 127, mute = 0, busy = 0, cmd_overflow = 0; pending slot empty; state IDLE.
- Reset asserted mid-sequence returns every output to its reset value immediately and discards pending.
- States: IDLE, DRAIN, QUIET, APPLY.
- SET_DIVISOR (any state): divisor <= cmd_data[7:0] on the next edge.
- SET_EDGE_DETECT_THRESHOLD (any state): lf_ed_threshold <= cmd_data[7:0] on the next edge.
  - Exception: an APPLY in the same cycle that loads default 127 has lower priority; the explicit write wins.
- SET_CONFREG in IDLE, with cmd_data[8:6] == current major_mode:
  - lf_field and lf_ed_toggle_mode update on the next edge.
  - No mute; busy stays 0; threshold unchanged.
- SET_CONFREG in IDLE, with cmd_data[8:6] != major_mode:
  - Latch the word as target.
  - Next edge: state DRAIN, busy = 1.
- DRAIN:
  - Exits on the first cycle ssp_frame_in == 0, or after DRAIN_TIMEOUT cycles in DRAIN, whichever comes first.
  - Next state QUIET; on entry mute = 1 and major_mode = 7.
  - Outputs are otherwise unchanged while in DRAIN.
- QUIET:
  - mute = 1 and major_mode = 7 for exactly GUARD_CYCLES cycles.
  - lf_field is forced 0 for the duration.
  - Then APPLY.
- APPLY (one cycle, mute still 1):
  - On exit edge: major_mode <= target[8:6], lf_field <= target[0], lf_ed_toggle_mode <= target[1], mute <= 0.
  - If target[8:6] == 1, lf_ed_threshold <= 127.
  - If pending is valid: it becomes the target, pending is cleared, next state DRAIN, busy stays 1.
  - Otherwise: next state IDLE, busy <= 0.
- SET_CONFREG while busy:
  - Stored in a one-deep pending slot; latest write wins.
  - If the slot was already full, cmd_overflow pulses on the next edge.
  - Pending is processed at APPLY even if its major mode equals the just-applied target. In that case the sequence still runs DRAIN/QUIET/APPLY; there is no shortcut while busy.
- SET_CONFREG with target major 7 follows the full sequence; the final major_mode is 7 with mute = 0.
- Counters are 8-bit and saturate-free: they reload on each state entry.

Test Plan:
- Reset, then SET_CONFREG 0x040 (major 1, field 0), with ssp_frame_in held 0:
  - busy rises at t+1.
  - mute = 1 and major_mode = 7 for 16 cycles, then 1 APPLY cycle.
  - Final major_mode = 1, lf_ed_threshold = 127, mute = 0, busy = 0.
- In IDLE with major 0, SET_CONFREG 0x001:
  - lf_field = 1 at t+1.
  - busy and mute stay 0; major_mode stays 0.
- Major change with ssp_frame_in held 1:
  - DRAIN lasts exactly 64 cycles.
  - QUIET then starts (timeout path).
- During QUIET, SET_CONFREG 0x0C0 then 0x080:
  - cmd_overflow pulses once.
  - After the first APPLY, a second sequence runs.
  - Final major_mode = 2.
- During QUIET, SET_DIVISOR 0x058 and SET_EDGE_DETECT_THRESHOLD 0x020, target major 1:
  - divisor = 88 immediately.
  - threshold ends at 127 after APPLY (APPLY default overrides the earlier write).
  - Repeat with the threshold write in the APPLY cycle: threshold ends at 32.
- Assert reset mid-QUIET:
  - Same cycle: mute = 0, major_mode = 7, busy = 0, divisor = 95.
  - Pending is lost; no later sequence occurs.
